// File: rtl/wr_req_assembler.sv
// wr_req_assembler
//   Buffers AXI AW requests in a FIFO and decodes each address into mem_addr_t
//   plus a one-hot rank-FSM select ({channel,rank}). Each queued request is
//   presented to its FSM as an address phase, followed by BURST_LENGTH W beats
//   streamed to the same FSM. Burst completion is decided by the beat count only.
//   Optional feature macro: WRASM_ERRCHK_EN (sticky last/id mismatch flags on err).
module wr_req_assembler #(
    parameter int ASSEMBLER_DEPTH = 8,
    parameter int BURST_LENGTH    = 8,
    parameter int NUM_FSM         = 8,
    parameter int AXI_DATAWIDTH   = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    aw_valid,
    input  logic [36:0]                             aw,
    output logic                                    aw_ready,
    input  logic                                    w_valid,
    input  logic [AXI_DATAWIDTH+AXI_DATAWIDTH/8+5:0] w,
    output logic                                    w_ready,
    output logic [NUM_FSM-1:0]                      req_valid,
    input  logic [NUM_FSM-1:0]                      fsm_aw_ready,
    output logic [31:0]                             mem_addr,
    output logic [3:0]                              mem_id,
    output logic                                    mem_user,
    output logic                                    data_valid,
    input  logic [NUM_FSM-1:0]                      fsm_w_ready,
    output logic [AXI_DATAWIDTH-1:0]                write_data,
    output logic [AXI_DATAWIDTH/8-1:0]              write_strb,
    output logic                                    last,
    output logic [1:0]                              err
);
    localparam int STRB_W  = AXI_DATAWIDTH / 8;
    localparam int SEL_W   = $clog2(NUM_FSM);
    localparam int CHWIDTH = 1;
    localparam int RKWIDTH = SEL_W - CHWIDTH;
    localparam int PTR_W   = $clog2(ASSEMBLER_DEPTH);
    localparam int CNT_W   = $clog2(BURST_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LENGTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(ASSEMBLER_DEPTH);

    // Channel and rank sit at the top of the address so {channel,rank} is the FSM index.
    typedef struct packed {
        logic [CHWIDTH-1:0]  channel;
        logic [RKWIDTH-1:0]  rank;
        logic [31-SEL_W:0]   offset;
    } mem_addr_t;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    // AW channel fields {id,addr,user}
    logic [3:0]   aw_id;
    mem_addr_t    aw_addr;
    logic         aw_user;
    logic [NUM_FSM-1:0] aw_fsm;

    assign aw_id   = aw[36:33];
    assign aw_addr = mem_addr_t'(aw[32:1]);
    assign aw_user = aw[0];
    assign aw_fsm  = NUM_FSM'(1) << {aw_addr.channel, aw_addr.rank};

    // W channel fields {data,user,id,last,strb}
    logic [AXI_DATAWIDTH-1:0] w_data;
    logic                     w_user;
    logic [3:0]               w_id;
    logic                     w_last;
    logic [STRB_W-1:0]        w_strb;

    assign {w_data, w_user, w_id, w_last, w_strb} = w;

    // Request FIFO storage and control
    logic [3:0]         fifo_id   [ASSEMBLER_DEPTH];
    mem_addr_t          fifo_addr [ASSEMBLER_DEPTH];
    logic               fifo_user [ASSEMBLER_DEPTH];
    logic [NUM_FSM-1:0] fifo_fsm  [ASSEMBLER_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic [CNT_W-1:0]   beat_cnt;

    state_t state;
    state_t state_nxt;

    logic               push;
    logic               pop;
    logic               addr_acc;
    logic               beat_acc;
    logic [NUM_FSM-1:0] head_fsm;

    assign head_fsm = fifo_fsm[rd_ptr];
    // A full FIFO refuses pushes even if the head pops in the same cycle.
    assign aw_ready = (fifo_cnt != FULL_CNT);
    assign push     = aw_valid & aw_ready;
    assign addr_acc = (state == ADDR) & (|(fsm_aw_ready & head_fsm));
    assign beat_acc = (state == DATA) & w_valid & w_ready;
    assign pop      = beat_acc & (beat_cnt == LAST_BEAT);

    // Entry payload is written on push; it needs no reset since fifo_cnt guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= aw_id;
            fifo_addr[wr_ptr] <= aw_addr;
            fifo_user[wr_ptr] <= aw_user;
            fifo_fsm[wr_ptr]  <= aw_fsm;
        end
    end

    // FIFO pointers, occupancy and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (pop)           beat_cnt <= '0;
            else if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> ADDR on a queued request, ADDR -> DATA on FSM accept,
    // DATA -> IDLE when the final beat is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_cnt != '0) state_nxt = ADDR;
            ADDR:    if (addr_acc)       state_nxt = DATA;
            DATA:    if (pop)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: head entry visible in ADDR/DATA, W passthrough only in DATA.
    always_comb begin
        req_valid  = '0;
        mem_addr   = '0;
        mem_id     = '0;
        mem_user   = 1'b0;
        w_ready    = 1'b0;
        data_valid = 1'b0;
        write_data = '0;
        write_strb = '0;
        last       = 1'b0;
        case (state)
            ADDR: begin
                req_valid = head_fsm;
                mem_addr  = fifo_addr[rd_ptr];
                mem_id    = fifo_id[rd_ptr];
                mem_user  = fifo_user[rd_ptr];
            end
            DATA: begin
                mem_addr   = fifo_addr[rd_ptr];
                mem_id     = fifo_id[rd_ptr];
                mem_user   = fifo_user[rd_ptr];
                w_ready    = |(fsm_w_ready & head_fsm);
                data_valid = w_valid;
                write_data = w_data;
                write_strb = w_strb;
                last       = (beat_cnt == LAST_BEAT);
            end
            default: ;
        endcase
    end

`ifdef WRASM_ERRCHK_EN
    logic [1:0] err_q;
    logic       unused_w;

    assign unused_w = w_user;

    // Sticky protocol checks on accepted beats; they never influence the data flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 2'b00;
        end else if (beat_acc) begin
            if (w_last != (beat_cnt == LAST_BEAT)) err_q[0] <= 1'b1;
            if (w_id != fifo_id[rd_ptr])           err_q[1] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_w;

    assign unused_w = ^{w_user, w_id, w_last};
    assign err      = 2'b00;
`endif

endmodule
